// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module  : matrix_pkg
// Brief   : Shared constants, FSM state type and element selector for the
//           3x3 matrix memory write/read streamers.
// Rev     : 1.0
// ============================================================================
package matrix_pkg;

    localparam int DIM    = 3;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = DIM * DIM;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Mux-tree select keeps out-of-range indices at zero instead of X.
    function automatic logic [DATA_W-1:0] elem_sel(
        input logic [DEPTH*DATA_W-1:0] flat,
        input logic [ADDR_W-1:0]       k
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (k == ADDR_W'(i)) r = flat[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_index_counter.sv
`default_nettype none
// ============================================================================
// Module  : matrix_index_counter
// Brief   : Linear index plus row/col counters over a DIM x DIM matrix, with
//           synchronous clear, enable, wrap at the last element and last flag.
// Rev     : 1.0
// ============================================================================
module matrix_index_counter #(
    parameter int DIM    = 3,
    parameter int ADDR_W = 4,
    parameter int RC_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic [RC_W-1:0]   row_o,
    output logic [RC_W-1:0]   col_o,
    output logic              last_o
);

    localparam int DEPTH = DIM * DIM;

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [RC_W-1:0]   col_q, col_d;

    assign last_o = (idx_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        idx_d = idx_q;
        row_d = row_q;
        col_d = col_q;
        if (clr_i || (en_i && last_o)) begin
            idx_d = '0;
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            idx_d = idx_q + 1'b1;
            if (col_q == RC_W'(DIM - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            idx_q <= idx_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign idx_o = idx_q;
    assign row_o = row_q;
    assign col_o = col_q;

endmodule
`default_nettype wire

// File: rtl/matrix_writer.sv
`default_nettype none
// ============================================================================
// Module  : matrix_writer
// Brief   : Captures a flat matrix on a valid/ready load, streams it onto the
//           memory write port under mem_ready stalls, then pulses a commit.
//           Define MATRIX_WRITER_TRANSPOSE_EN to write the transpose instead.
// Rev     : 1.0
// ============================================================================
module matrix_writer #(
    parameter int DIM    = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [DIM*DIM*DATA_W-1:0] load_data,
    input  logic                      mem_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic                      mem_write_enable,
    output logic                      mem_read_enable,
    output logic                      busy,
    output logic                      done
);

    import matrix_pkg::*;

    localparam int DEPTH = DIM * DIM;
    localparam int RC_W  = (DIM > 1) ? $clog2(DIM) : 1;

    state_e                    state_q;
    logic [DEPTH*DATA_W-1:0]   buf_q;

    logic [ADDR_W-1:0]         idx;
    logic [RC_W-1:0]           row;
    logic [RC_W-1:0]           col;
    logic                      last;
    logic                      capture;
    logic                      wr_fire;
    logic [ADDR_W-1:0]         sel_idx;

    assign capture = (state_q == ST_IDLE) && load_valid;
    assign wr_fire = (state_q == ST_WRITE) && mem_ready;

    matrix_index_counter #(
        .DIM    (DIM),
        .ADDR_W (ADDR_W),
        .RC_W   (RC_W)
    ) u_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (capture),
        .en_i   (wr_fire),
        .idx_o  (idx),
        .row_o  (row),
        .col_o  (col),
        .last_o (last)
    );

    // Buffer element feeding address idx = row*DIM + col.
`ifdef MATRIX_WRITER_TRANSPOSE_EN
    assign sel_idx = ADDR_W'(col) * ADDR_W'(DIM) + ADDR_W'(row);
`else
    assign sel_idx = ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        buf_q   <= load_data;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready && last) state_q <= ST_COMMIT;
                end
                ST_COMMIT: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Counter wraps to 0 after the last element, so idx reads 0 outside WRITE.
    assign mem_addr         = idx;
    assign mem_write_data   = (state_q == ST_WRITE) ? elem_sel(buf_q, sel_idx) : '0;
    assign mem_write_enable = wr_fire;
    assign mem_read_enable  = (state_q == ST_COMMIT);
    assign done             = (state_q == ST_COMMIT);
    assign load_ready       = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_matrix_writer
// Brief   : Directed self-checking bench for matrix_writer (either build).
// Rev     : 1.0
// ============================================================================
module tb_matrix_writer;

    localparam logic [71:0] M1 = 72'h090807060504030201;
    localparam logic [71:0] M2 = 72'h998877665544332211;
    localparam logic [71:0] M3 = 72'hA9B8C7D6E5F4132435;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [71:0] load_data = '0;
    logic        mem_ready = 1'b0;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mem [16];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          dbl_done = 0;
    logic        prev_done = 1'b0;
    logic [16:0] w_obs;

    matrix_writer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_data        (load_data),
        .mem_ready        (mem_ready),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    assign w_obs = {load_ready, busy, mem_write_enable, mem_read_enable, done,
                    mem_addr, mem_write_data};

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_addr] <= mem_write_data;
            wr_cnt        <= wr_cnt + 1;
        end
        if (mem_read_enable) rd_cnt <= rd_cnt + 1;
        if (done && prev_done) dbl_done <= dbl_done + 1;
        prev_done <= done;
    end

    function automatic logic [7:0] exp_elem(input logic [71:0] m, input int k);
        int e;
`ifdef MATRIX_WRITER_TRANSPOSE_EN
        e = (k % 3) * 3 + (k / 3);
`else
        e = k;
`endif
        return m[e*8 +: 8];
    endfunction

    function automatic logic [16:0] mk(input logic lr, input logic bz, input logic we,
                                       input logic re, input logic dn,
                                       input logic [3:0] a, input logic [7:0] d);
        return {lr, bz, we, re, dn, a, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load_valid = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (w_obs !== mk(1, 0, 0, 0, 0, 4'd0, 8'd0)) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp %h", w_obs, mk(1, 0, 0, 0, 0, 4'd0, 8'd0));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int w0, r0;
        tick;
        load_data = M1; load_valid = 1'b1; mem_ready = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt;
        #1;
        vectors++;
        if (w_obs[16:12] !== 5'b10000) begin
            miscompares++;
            $display("FAIL basic_idle got %b exp %b", w_obs[16:12], 5'b10000);
        end
        tick;
        load_valid = 1'b0;
        #1;
        for (int c = 1; c <= 9; c++) begin
            vectors++;
            if (w_obs !== mk(0, 1, 1, 0, 0, 4'(c - 1), exp_elem(M1, c - 1))) begin
                miscompares++;
                $display("FAIL basic_write cycle=%0d got %h exp %h", c, w_obs,
                         mk(0, 1, 1, 0, 0, 4'(c - 1), exp_elem(M1, c - 1)));
            end
            tick; #1;
        end
        vectors++;
        if (w_obs[16:12] !== 5'b01011) begin
            miscompares++;
            $display("FAIL basic_commit got %b exp %b", w_obs[16:12], 5'b01011);
        end
        vectors++;
        if (wr_cnt - w0 !== 9) begin
            miscompares++;
            $display("FAIL basic_strobes got %0d exp 9", wr_cnt - w0);
        end
        tick; #1;
        vectors++;
        if (w_obs[16:12] !== 5'b10000 || rd_cnt - r0 !== 1) begin
            miscompares++;
            $display("FAIL basic_ready_again got %b/%0d exp 10000/1", w_obs[16:12], rd_cnt - r0);
        end
    endtask

    task automatic test_stall;
        int w0;
        int a;
        tick;
        load_data = M1; load_valid = 1'b1; mem_ready = 1'b1;
        w0 = wr_cnt;
        tick;
        load_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            mem_ready = !(c >= 3 && c <= 5);
            #1;
            a = (c < 3) ? c - 1 : ((c <= 5) ? 2 : c - 4);
            vectors++;
            if (w_obs !== mk(0, 1, mem_ready, 0, 0, 4'(a), exp_elem(M1, a))) begin
                miscompares++;
                $display("FAIL stall_write cycle=%0d got %h exp %h", c, w_obs,
                         mk(0, 1, mem_ready, 0, 0, 4'(a), exp_elem(M1, a)));
            end
            tick;
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (w_obs[16:12] !== 5'b01011 || wr_cnt - w0 !== 9) begin
            miscompares++;
            $display("FAIL stall_commit got %b/%0d exp 01011/9", w_obs[16:12], wr_cnt - w0);
        end
    endtask

    task automatic test_ignore_load;
        tick;
        load_data = M3; load_valid = 1'b1; mem_ready = 1'b1;
        tick;
        load_data = M2;
        for (int c = 1; c <= 9; c++) begin
            #1;
            vectors++;
            if (w_obs !== mk(0, 1, 1, 0, 0, 4'(c - 1), exp_elem(M3, c - 1))) begin
                miscompares++;
                $display("FAIL ignore_write cycle=%0d got %h exp %h", c, w_obs,
                         mk(0, 1, 1, 0, 0, 4'(c - 1), exp_elem(M3, c - 1)));
            end
            tick;
        end
        load_valid = 1'b0;
        #1;
        vectors++;
        if (w_obs[16:12] !== 5'b01011) begin
            miscompares++;
            $display("FAIL ignore_commit got %b exp %b", w_obs[16:12], 5'b01011);
        end
        tick;
        for (int k = 0; k < 9; k++) begin
            vectors++;
            if (mem[k] !== exp_elem(M3, k)) begin
                miscompares++;
                $display("FAIL ignore_mem addr=%0d got %h exp %h", k, mem[k], exp_elem(M3, k));
            end
        end
    endtask

    task automatic test_reset_mid;
        int r0;
        tick;
        load_data = M2; load_valid = 1'b1; mem_ready = 1'b1;
        r0 = rd_cnt;
        tick;
        load_valid = 1'b0;
        repeat (4) tick;
        #1;
        vectors++;
        if (mem_addr !== 4'd4 || mem_write_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre got addr %0d we %b exp 4 1", mem_addr, mem_write_enable);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (w_obs !== mk(1, 0, 0, 0, 0, 4'd0, 8'd0)) begin
            miscompares++;
            $display("FAIL rstmid_async got %h exp %h", w_obs, mk(1, 0, 0, 0, 0, 4'd0, 8'd0));
        end
        repeat (2) tick;
        vectors++;
        if (mem[3] !== exp_elem(M2, 3) || mem[4] !== exp_elem(M3, 4)) begin
            miscompares++;
            $display("FAIL rstmid_mem got %h %h exp %h %h", mem[3], mem[4],
                     exp_elem(M2, 3), exp_elem(M3, 4));
        end
        rst_n = 1'b1;
        tick;
        vectors++;
        if (rd_cnt !== r0) begin
            miscompares++;
            $display("FAIL rstmid_no_commit got %0d exp %0d", rd_cnt, r0);
        end
        load_data = M1; load_valid = 1'b1;
        tick;
        load_valid = 1'b0;
        #1;
        vectors++;
        if (w_obs !== mk(0, 1, 1, 0, 0, 4'd0, exp_elem(M1, 0))) begin
            miscompares++;
            $display("FAIL rstmid_restart got %h exp %h", w_obs, mk(0, 1, 1, 0, 0, 4'd0, exp_elem(M1, 0)));
        end
        repeat (9) tick;
        #1;
        vectors++;
        if (w_obs[16:12] !== 5'b01011) begin
            miscompares++;
            $display("FAIL rstmid_commit got %b exp %b", w_obs[16:12], 5'b01011);
        end
    endtask

    task automatic test_back_to_back;
        int w0, r0, d0;
        logic [4:0] eh;
        tick;
        load_data = M1; load_valid = 1'b1; mem_ready = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt; d0 = dbl_done;
        tick;
        load_data = M2;
        for (int c = 1; c <= 22; c++) begin
            if (c == 22) load_valid = 1'b0;
            #1;
            if (c <= 9 || (c >= 12 && c <= 20)) begin
                vectors++;
                if (c <= 9 && w_obs !== mk(0, 1, 1, 0, 0, 4'(c - 1), exp_elem(M1, c - 1))) begin
                    miscompares++;
                    $display("FAIL b2b_write1 cycle=%0d got %h exp %h", c, w_obs,
                             mk(0, 1, 1, 0, 0, 4'(c - 1), exp_elem(M1, c - 1)));
                end
                if (c >= 12 && w_obs !== mk(0, 1, 1, 0, 0, 4'(c - 12), exp_elem(M2, c - 12))) begin
                    miscompares++;
                    $display("FAIL b2b_write2 cycle=%0d got %h exp %h", c, w_obs,
                             mk(0, 1, 1, 0, 0, 4'(c - 12), exp_elem(M2, c - 12)));
                end
            end else begin
                eh = (c == 10 || c == 21) ? 5'b01011 : 5'b10000;
                vectors++;
                if (w_obs[16:12] !== eh) begin
                    miscompares++;
                    $display("FAIL b2b_handshake cycle=%0d got %b exp %b", c, w_obs[16:12], eh);
                end
            end
            tick;
        end
        vectors++;
        if (rd_cnt - r0 !== 2 || wr_cnt - w0 !== 18 || dbl_done !== d0) begin
            miscompares++;
            $display("FAIL b2b_totals got rd %0d wr %0d dbl %0d exp 2 18 %0d",
                     rd_cnt - r0, wr_cnt - w0, dbl_done, d0);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_ignore_load;
        test_reset_mid;
        test_back_to_back;
        vectors++;
        if (dbl_done !== 0) begin
            miscompares++;
            $display("FAIL done_consecutive got %0d exp 0", dbl_done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
